// File: rtl/uart_link_pkg.sv
// Shared UART link constants, FSM encoding, snapshot payload and byte layout.
package uart_link_pkg;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned PKT_LEN        = 10;
  localparam int unsigned CHK_IDX        = 9;
  localparam int unsigned IDX_W          = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned COORD_W        = 12;
  localparam int unsigned SCORE_W        = 4;
  localparam int unsigned DIV_W          = 8;

  // Scheduler FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SNAP = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Frozen copy of the local game state carried by one packet
  typedef struct packed {
    logic [COORD_W-1:0] xpos;
    logic [COORD_W-1:0] ypos;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               endgame;
    logic               whistle;
    logic               last_touch;
  } snap_t;

  // Packet byte at position idx; idx CHK_IDX carries the running checksum
  function automatic logic [BYTE_W-1:0] pkt_byte(
    input snap_t             s,
    input logic [IDX_W-1:0]  idx,
    input logic [BYTE_W-1:0] hdr,
    input logic [BYTE_W-1:0] chk
  );
    logic [BYTE_W-1:0] b;
    case (idx)
      4'd0:    b = hdr;
      4'd1:    b = s.xpos[11:4];
      4'd2:    b = {s.xpos[3:0], s.ypos[11:8]};
      4'd3:    b = s.ypos[7:0];
      4'd4:    b = s.ball_x[11:4];
      4'd5:    b = {s.ball_x[3:0], s.ball_y[11:8]};
      4'd6:    b = s.ball_y[7:0];
      4'd7:    b = {s.score1, s.score2};
      4'd8:    b = {5'b00000, s.endgame, s.whistle, s.last_touch};
      4'd9:    b = chk;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_mux.sv
// Combinational packet byte selector: snapshot + index + checksum -> byte.
module uart_pkt_mux
  import uart_link_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  snap_t             i_snap,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [BYTE_W-1:0] i_chk,
  output logic [BYTE_W-1:0] o_byte
);

  // Byte layout lives in the package so the deframer decodes the same map
  always_comb begin
    o_byte = pkt_byte(i_snap, i_idx, HEADER, i_chk);
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Frame-tick driven packet scheduler: snapshots game state and streams a
// fixed 10-byte packet to the UART TX byte port over valid/ready.
module uart_frame_scheduler
  import uart_link_pkg::*;
#(
  parameter logic [7:0]  HEADER       = HEADER_DEFAULT,
  parameter int unsigned PERIOD_TICKS = 1
) (
  input  logic                clk65MHz,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic [COORD_W-1:0]  xpos_mux,
  input  logic [COORD_W-1:0]  ypos_mux,
  input  logic [COORD_W-1:0]  ball_xpos,
  input  logic [COORD_W-1:0]  ball_ypos,
  input  logic [SCORE_W-1:0]  score_pl1,
  input  logic [SCORE_W-1:0]  score_pl2,
  input  logic                endgame,
  input  logic                whistle,
  input  logic                last_touch,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                pkt_done,
  output logic [7:0]          overrun_cnt
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PERIOD_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_CHK   = IDX_W'(CHK_IDX);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHK_IDX - 1);

  logic [1:0]        r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div,   w_div_nxt;
  snap_t             r_snap,  w_snap_nxt;
  logic [IDX_W-1:0]  r_idx,   w_idx_nxt;
  logic [BYTE_W-1:0] r_chk,   w_chk_nxt;
  logic [BYTE_W-1:0] r_tx_data, w_tx_data_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_pkt_done, w_pkt_done_nxt;
  logic [7:0]        r_ovr,   w_ovr_nxt;

  logic              w_send;
  logic              w_hs;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [BYTE_W-1:0] w_chk_upd;
  logic [BYTE_W-1:0] w_next_byte;

  // Byte that follows the one currently on the port, using the updated checksum
  uart_pkt_mux #(
    .HEADER (HEADER)
  ) u_mux (
    .i_snap (r_snap),
    .i_idx  (w_idx_inc),
    .i_chk  (w_chk_upd),
    .o_byte (w_next_byte)
  );

  // Tick divider, overrun counter and handshake helpers
  always_comb begin
    w_send    = frame_tick && (r_div == DIV_LAST);
    w_div_nxt = r_div;
    if (frame_tick) begin
      w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
    w_ovr_nxt = r_ovr;
    if (w_send && (r_state != ST_IDLE) && (r_ovr != 8'hFF)) begin
      w_ovr_nxt = r_ovr + 8'd1;
    end
    w_hs      = r_tx_valid && tx_ready;
    w_idx_inc = r_idx + IDX_W'(1);
    w_chk_upd = r_chk;
    if ((r_idx >= IDX_FIRST) && (r_idx <= IDX_LAST)) begin
      w_chk_upd = r_chk ^ r_tx_data;
    end
  end

  // Next-state and registered-output logic of the packet FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_snap_nxt     = r_snap;
    w_idx_nxt      = r_idx;
    w_chk_nxt      = r_chk;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_busy_nxt     = r_busy;
    w_pkt_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_send) begin
          w_state_nxt = ST_SNAP;
        end
      end
      ST_SNAP: begin
        w_snap_nxt.xpos       = xpos_mux;
        w_snap_nxt.ypos       = ypos_mux;
        w_snap_nxt.ball_x     = ball_xpos;
        w_snap_nxt.ball_y     = ball_ypos;
        w_snap_nxt.score1     = score_pl1;
        w_snap_nxt.score2     = score_pl2;
        w_snap_nxt.endgame    = endgame;
        w_snap_nxt.whistle    = whistle;
        w_snap_nxt.last_touch = last_touch;
        w_chk_nxt      = '0;
        w_idx_nxt      = '0;
        w_busy_nxt     = 1'b1;
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = HEADER;
        w_state_nxt    = ST_SEND;
      end
      ST_SEND: begin
        if (w_hs) begin
          if (r_idx == IDX_CHK) begin
            w_tx_valid_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
            w_pkt_done_nxt = 1'b1;
            w_state_nxt    = ST_DONE;
          end else begin
            w_idx_nxt     = w_idx_inc;
            w_chk_nxt     = w_chk_upd;
            w_tx_data_nxt = w_next_byte;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk65MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_snap     <= '0;
      r_idx      <= '0;
      r_chk      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_pkt_done <= 1'b0;
      r_ovr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_snap     <= w_snap_nxt;
      r_idx      <= w_idx_nxt;
      r_chk      <= w_chk_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_pkt_done <= w_pkt_done_nxt;
      r_ovr      <= w_ovr_nxt;
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign busy        = r_busy;
  assign pkt_done    = r_pkt_done;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Self-checking bench for uart_frame_scheduler: vector table, directed corner
// sequences and randomized traffic against a cycle-level packet model.
module tb_uart_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [11:0] xpos_mux, ypos_mux, ball_xpos, ball_ypos;
  logic [3:0]  score_pl1, score_pl2;
  logic        endgame, whistle, last_touch;
  logic        tx_ready;
  logic [7:0]  tx_data, t3_data;
  logic        tx_valid, t3_valid;
  logic        busy, t3_busy;
  logic        pkt_done, t3_done;
  logic [7:0]  overrun_cnt, t3_ovr;

  always #5 clk = ~clk;

  uart_frame_scheduler #(.HEADER(8'hA5), .PERIOD_TICKS(1)) dut (
    .clk65MHz(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .xpos_mux(xpos_mux), .ypos_mux(ypos_mux), .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
    .score_pl1(score_pl1), .score_pl2(score_pl2), .endgame(endgame), .whistle(whistle),
    .last_touch(last_touch), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .pkt_done(pkt_done), .overrun_cnt(overrun_cnt));

  uart_frame_scheduler #(.HEADER(8'hA5), .PERIOD_TICKS(3)) dut3 (
    .clk65MHz(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .xpos_mux(xpos_mux), .ypos_mux(ypos_mux), .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
    .score_pl1(score_pl1), .score_pl2(score_pl2), .endgame(endgame), .whistle(whistle),
    .last_touch(last_touch), .tx_data(t3_data), .tx_valid(t3_valid), .tx_ready(tx_ready),
    .busy(t3_busy), .pkt_done(t3_done), .overrun_cnt(t3_ovr));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [7:0] got[$];

  // Reference model state (dut with one packet per tick)
  bit          m_inflight;
  int          m_start, m_acc, m_done, m_ovr;
  logic [79:0] m_pkt;

  typedef struct {
    logic [11:0] x, y, bx, by;
    logic [3:0]  s1, s2;
    logic [2:0]  fl;
    logic [79:0] exp;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Packet contents from field values using plain arithmetic
  function automatic logic [79:0] build_packet(input int x, input int y, input int bx,
                                               input int by, input int s1, input int s2,
                                               input int fl);
    int b[10];
    logic [79:0] p;
    b[0] = 'hA5;
    b[1] = x / 16;
    b[2] = (x % 16) * 16 + y / 256;
    b[3] = y % 256;
    b[4] = bx / 16;
    b[5] = (bx % 16) * 16 + by / 256;
    b[6] = by % 256;
    b[7] = s1 * 16 + s2;
    b[8] = fl;
    b[9] = 0;
    for (int i = 1; i <= 8; i++) b[9] = b[9] ^ b[i];
    for (int i = 0; i < 10; i++) p[79-8*i -: 8] = 8'(b[i]);
    return p;
  endfunction

  function automatic logic [79:0] cur_packet();
    return build_packet(int'(xpos_mux), int'(ypos_mux), int'(ball_xpos), int'(ball_ypos),
                        int'(score_pl1), int'(score_pl2),
                        int'({endgame, whistle, last_touch}));
  endfunction

  task automatic set_inputs(input logic [11:0] x, input logic [11:0] y, input logic [11:0] bx,
                            input logic [11:0] by, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [2:0] fl);
    xpos_mux = x; ypos_mux = y; ball_xpos = bx; ball_ypos = by;
    score_pl1 = s1; score_pl2 = s2; {endgame, whistle, last_touch} = fl;
  endtask

  task automatic rand_inputs();
    set_inputs(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
               4'($urandom), 4'($urandom), 3'($urandom));
  endtask

  task automatic model_reset();
    m_inflight = 1'b0; m_start = 0; m_acc = 0; m_done = -1; m_ovr = 0;
    m_pkt = '0;
  endtask

  // One clock: check outputs against the model, advance model, clock the DUT
  task automatic run_cycle(input bit tick, input bit rdy);
    bit ev;
    frame_tick = tick;
    tx_ready   = rdy;
    ev = m_inflight && (cyc >= m_start + 2) && (m_acc < 10);
    chk("tx_valid", 32'(tx_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(ev));
    chk("pkt_done", 32'(pkt_done), 32'(m_done == cyc));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    if (ev) chk("tx_data", 32'(tx_data), 32'(m_pkt[79-8*m_acc -: 8]));
    if (tx_valid && rdy) got.push_back(tx_data);
    if (m_inflight && cyc == m_start + 1) m_pkt = cur_packet();
    if (ev && rdy) begin
      m_acc++;
      if (m_acc == 10) m_done = cyc + 1;
    end
    if (tick) begin
      if (!m_inflight) begin
        m_inflight = 1'b1; m_start = cyc; m_acc = 0; m_done = -1;
      end else if (m_ovr < 255) begin
        m_ovr++;
      end
    end
    if (m_inflight && m_done == cyc) m_inflight = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt_done", 32'(pkt_done), 0);
    chk("rst_overrun", 32'(overrun_cnt), 0);
    chk("rst3_valid_busy_ovr", 32'({t3_valid, t3_busy, t3_ovr}), 0);
    model_reset();
    run_cycle(1'b0, 1'b1);
    rst_n = 1'b1;
    run_cycle(1'b0, 1'b1);
  endtask

  // One tick then collect until pkt_done; reports valid/done latency from the tick
  task automatic send_pkt(input bit rnd, output int t_valid, output int t_done);
    int t0;
    got.delete();
    t_valid = -1; t_done = -1; t0 = cyc;
    run_cycle(1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    for (int k = 0; k < 300; k++) begin
      if (tx_valid && t_valid < 0) t_valid = cyc - t0;
      if (pkt_done) begin
        t_done = cyc - t0;
        break;
      end
      run_cycle(1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    chk("pkt_complete", 32'(t_done >= 0), 1);
    run_cycle(1'b0, 1'b1);
  endtask

  task automatic cmp_pkt(input string nm, input logic [79:0] exp);
    chk({nm, "_len"}, 32'(got.size()), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), 32'(got[i]), 32'(exp[79-8*i -: 8]));
  endtask

  initial begin
    int tv, td, cnt;
    logic [79:0] pa, pb;
    frame_tick = 1'b0; tx_ready = 1'b1; rst_n = 1'b1;
    set_inputs('0, '0, '0, '0, '0, '0, '0);
    model_reset();
    // XOR of bytes 1..8 worked by hand for each row
    vt[0] = '{12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 3'b101, 80'hA5_12_34_56_78_9A_BC_35_05_1E};
    vt[1] = '{12'h000, 12'h000, 12'h000, 12'h000, 4'd0, 4'd0, 3'b000, 80'hA5_00_00_00_00_00_00_00_00_00};
    vt[2] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'hF, 4'hF, 3'b111, 80'hA5_FF_FF_FF_FF_FF_FF_FF_07_F8};
    vt[3] = '{12'h800, 12'h001, 12'h000, 12'hFFF, 4'h0, 4'hF, 3'b010, 80'hA5_80_00_01_00_0F_FF_0F_02_7C};
    #2;
    do_reset();

    // Vector table: packet contents and latency with tx_ready held high
    for (int r = 0; r < 4; r++) begin
      set_inputs(vt[r].x, vt[r].y, vt[r].bx, vt[r].by, vt[r].s1, vt[r].s2, vt[r].fl);
      send_pkt(1'b0, tv, td);
      chk($sformatf("row%0d_valid_lat", r), 32'(tv), 2);
      chk($sformatf("row%0d_done_lat", r), 32'(td), 12);
      cmp_pkt($sformatf("row%0d", r), vt[r].exp);
    end

    // Random backpressure, same packet content
    for (int r = 0; r < 4; r++) begin
      rand_inputs();
      pa = cur_packet();
      send_pkt(1'b1, tv, td);
      cmp_pkt("bp", pa);
    end

    // Inputs change mid-packet: old snapshot now, new values next packet
    set_inputs(12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 3'b101);
    pa = cur_packet();
    got.delete();
    run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b1);
    set_inputs(12'hFED, 12'h0C0, 12'h3A1, 12'h55A, 4'd9, 4'd1, 3'b011);
    pb = cur_packet();
    for (int k = 0; k < 30 && !pkt_done; k++) run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);
    cmp_pkt("frozen", pa);
    send_pkt(1'b0, tv, td);
    cmp_pkt("updated", pb);

    // Stall with 300 ticks: overrun saturates, busy holds
    run_cycle(1'b1, 1'b0);
    for (int k = 0; k < 299; k++) run_cycle(1'b1, 1'b0);
    chk("ovr_sat", 32'(overrun_cnt), 255);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_valid", 32'(tx_valid), 1);
    for (int k = 0; k < 30 && !pkt_done; k++) run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);
    chk("ovr_after", 32'(overrun_cnt), 255);

    // PERIOD_TICKS=3 instance: packets on ticks 3, 6, 9 only
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      run_cycle(1'b1, 1'b1);
      cnt = 0;
      for (int j = 0; j < 14; j++) begin
        if (t3_done) cnt++;
        run_cycle(1'b0, 1'b1);
      end
      chk($sformatf("p3_tick%0d", k), 32'(cnt), 32'(k % 3 == 0));
    end
    chk("p3_ovr", 32'(t3_ovr), 0);

    // Reset after byte 4 accepted, then a clean full packet
    rand_inputs();
    got.delete();
    run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 20 && got.size() < 5; k++) run_cycle(1'b0, 1'b1);
    chk("pre_rst_bytes", 32'(got.size()), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(tx_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    model_reset();
    @(posedge clk); #1; cyc++;
    rst_n = 1'b1;
    run_cycle(1'b0, 1'b1);
    rand_inputs();
    pa = cur_packet();
    send_pkt(1'b0, tv, td);
    chk("postrst_lat", 32'(tv), 2);
    cmp_pkt("postrst", pa);

    // Randomized traffic: sparse ticks, random backpressure and inputs
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rand_inputs();
      run_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 20; k++) run_cycle(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
